control_unit: RTL

- Hardwired Moore-style control sequencer for the Mini-SRC bus datapath.
- Steps every instruction through fetch (T0–T2) and an opcode-dependent execute sequence (T3–T7).
- Drives every bus-out, register-in, memory, select-logic and CON control input of the datapath.
- Reads back IR and the CON flip-flop output, and stops on halt or an external stop request.

---
 rtl/cu_pkg.sv | 60 ++++++
 rtl/control_unit.sv | 105 ++++++++++
 2 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: shared types, opcode encodings and per-opcode sequence length for control_unit.
package cu_pkg;

    localparam int OPC_W = 5;
    localparam int IR_W  = 32;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    localparam logic [OPC_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OPC_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'b01000;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'b01001;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'b01010;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b01011;
    localparam logic [OPC_W-1:0] OP_ANDI = 5'b01100;
    localparam logic [OPC_W-1:0] OP_ORI  = 5'b01101;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'b01110;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPC_W-1:0] OP_NEG  = 5'b10000;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'b10001;
    localparam logic [OPC_W-1:0] OP_BR   = 5'b10010;
    localparam logic [OPC_W-1:0] OP_JR   = 5'b10011;
    localparam logic [OPC_W-1:0] OP_JAL  = 5'b10100;
    localparam logic [OPC_W-1:0] OP_IN   = 5'b10101;
    localparam logic [OPC_W-1:0] OP_OUT  = 5'b10110;
    localparam logic [OPC_W-1:0] OP_MFHI = 5'b10111;
    localparam logic [OPC_W-1:0] OP_MFLO = 5'b11000;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'b11001;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

    // Field order matches the port concatenation in control_unit.
    typedef struct packed {
        logic pc_out, zhigh_out, zlow_out, hi_out, lo_out, mdr_out, inport_out, c_out, ba_out;
        logic pc_in, inc_pc, mar_in, mdr_in, ir_in, y_in, hi_in, lo_in, zhigh_in, zlow_in, outport_in, con_in;
        logic read, write;
        logic gra, grb, grc, rin, rout;
    } ctrl_t;

    // Final execute step per opcode. nop, halt and undefined opcodes spend a
    // single idle T3, because the new opcode is only visible from T3 onwards.
    function automatic state_t last_step(input logic [OPC_W-1:0] op);
        case (op)
            OP_LD, OP_ST:                   return S_T7;
            OP_MUL, OP_DIV, OP_BR:          return S_T6;
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
            OP_ADDI, OP_ANDI, OP_ORI:       return S_T5;
            OP_NEG, OP_NOT, OP_JAL:         return S_T4;
            default:                        return S_T3;
        endcase
    endfunction

endpackage

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for the Mini-SRC datapath.
//   clock/clear : clock and asynchronous active-low reset
//   ir/con/stop : instruction register, branch condition, halt request
//   run         : high while sequencing
//   remaining outputs: bus-out enables, register loads, RAM strobes, select logic
module control_unit
    import cu_pkg::*;
(
    input  logic            clock,
    input  logic            clear,
    input  logic [IR_W-1:0] ir,
    input  logic            con,
    input  logic            stop,
    output logic            run,
    output logic PCout, Zhighout, Zlowout, HIout, LOout, MDRout, InPortout, Cout, BAout,
    output logic PCin, IncPC, MARin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin, OutPortin, CONin,
    output logic Read, Write,
    output logic Gra, Grb, Grc, Rin, Rout
);

    state_t           state_q, state_d;
    ctrl_t            c;
    logic [OPC_W-1:0] opc;
    logic             ir_unused;
    logic             t3, t4, t5, t6, t7, is_st, is_ldi;

    assign opc       = ir[IR_W-1 -: OPC_W];
    assign ir_unused = ^ir[IR_W-OPC_W-1:0];
    assign t3        = state_q == S_T3;
    assign t4        = state_q == S_T4;
    assign t5        = state_q == S_T5;
    assign t6        = state_q == S_T6;
    assign t7        = state_q == S_T7;
    assign is_st     = opc == OP_ST;
    assign is_ldi    = opc == OP_LDI;
    assign run       = state_q != S_RESET && state_q != S_HALT;

    assign {PCout, Zhighout, Zlowout, HIout, LOout, MDRout, InPortout, Cout, BAout,
            PCin, IncPC, MARin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin, OutPortin, CONin,
            Read, Write, Gra, Grb, Grc, Rin, Rout} = c;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state_q <= S_RESET;
        else        state_q <= state_d;
    end

    // Fetch states never match last_step (always T3 or later), so a stale
    // opcode in ir during T0-T2 cannot end the instruction early.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_HALT:  state_d = S_HALT;
            default: state_d = (state_q == last_step(opc)) ? ((stop || opc == OP_HALT) ? S_HALT : S_T0)
                                                          : state_t'(state_q + 4'd1);
        endcase
    end

    always_comb begin
        c = '0;
        case (state_q)
            S_T0: begin c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; end
            S_T1: begin c.read = 1'b1; c.mdr_in = 1'b1; end
            S_T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                case (opc)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
                        c.grb = t3; c.grc = t4; c.rout = t3 | t4; c.y_in = t3; c.zlow_in = t4;
                        c.zlow_out = t5; c.gra = t5; c.rin = t5;
                    end
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
                        c.grb = t3; c.rout = t3 & ~is_ldi; c.ba_out = t3 & is_ldi; c.y_in = t3;
                        c.c_out = t4; c.zlow_in = t4; c.zlow_out = t5; c.gra = t5; c.rin = t5;
                    end
                    OP_LD, OP_ST: begin
                        c.grb = t3; c.ba_out = t3; c.y_in = t3; c.c_out = t4; c.zlow_in = t4;
                        c.zlow_out = t5; c.mar_in = t5; c.mdr_in = t6;
                        c.read = t6 & ~is_st; c.rout = t6 & is_st; c.gra = (t6 & is_st) | (t7 & ~is_st);
                        c.mdr_out = t7 & ~is_st; c.rin = t7 & ~is_st; c.write = t7 & is_st;
                    end
                    OP_MUL, OP_DIV: begin
                        c.gra = t3; c.rout = t3 | t4; c.y_in = t3; c.grb = t4; c.zlow_in = t4; c.zhigh_in = t4;
                        c.zlow_out = t5; c.lo_in = t5; c.zhigh_out = t6; c.hi_in = t6;
                    end
                    OP_NEG, OP_NOT: begin
                        c.grb = t3; c.rout = t3; c.zlow_in = t3; c.zlow_out = t4; c.gra = t4; c.rin = t4;
                    end
                    OP_BR: begin
                        c.gra = t3; c.rout = t3; c.con_in = t3; c.pc_out = t4; c.y_in = t4;
                        c.c_out = t5; c.zlow_in = t5; c.zlow_out = t6; c.pc_in = t6 & con;
                    end
                    OP_JR:   begin c.gra = t3; c.rout = t3; c.pc_in = t3; end
                    OP_JAL:  begin c.pc_out = t3; c.grb = t3; c.rin = t3; c.gra = t4; c.rout = t4; c.pc_in = t4; end
                    OP_IN:   begin c.inport_out = t3; c.gra = t3; c.rin = t3; end
                    OP_OUT:  begin c.gra = t3; c.rout = t3; c.outport_in = t3; end
                    OP_MFHI: begin c.hi_out = t3; c.gra = t3; c.rin = t3; end
                    OP_MFLO: begin c.lo_out = t3; c.gra = t3; c.rin = t3; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule
